ifu_fetch_ctrl: RTL and testbench

- Instruction fetch unit that sits directly upstream of the instruction cache.
- Owns the architectural fetch PC and issues one fetch request at a time to the cache.
- Collects returned instructions into a small FIFO and hands them to the decode stage with a valid/ready handshake.
- Handles redirects (branch/jump/trap) and fence.i from the execute stage, including discarding a fetch already in flight.

---
 rtl/ifu_fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Fetch control: one outstanding I$ request, registered instruction FIFO to decode (1 cycle response->o_valid).
// Backpressure: i_ready low holds the FIFO head; new fetches only issue while a FIFO slot is free.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [31:0] o_pc,
  output logic        o_fetch_valid,
  output logic        o_fencei,
  input  logic [31:0] i_inst,
  input  logic        i_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_fencei_req
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;

  logic [31:0]     r_pc;
  logic [31:0]     r_req_pc;
  logic            r_fetch_valid;
  logic            r_fencei;
  logic            r_fence_pend;

  logic [31:0]     r_mem_inst [FIFO_DEPTH];
  logic [31:0]     r_mem_pc   [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_unused_pc_lsb;
  assign w_unused_pc_lsb = ^i_redirect_pc[1:0];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Redirect wins over issue and push; a response coincident with a redirect is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_redirect && (r_count < DEPTH_C)) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_redirect) begin
          w_state_nxt = i_inst_valid ? S_IDLE : S_DISCARD;
        end else if (i_inst_valid) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (i_inst_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pop = (r_count != '0) && i_ready && !i_redirect;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_pc          <= RESET_PC;
      r_req_pc      <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_fencei      <= 1'b0;
      r_fence_pend  <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_fetch_valid <= w_issue;
      r_fencei      <= w_issue & r_fence_pend;
      // A fence.i request landing on an issue cycle belongs to the next fetch.
      if (w_issue) begin
        r_req_pc     <= r_pc;
        r_fence_pend <= i_fencei_req;
      end else begin
        r_fence_pend <= r_fence_pend | i_fencei_req;
      end

      if (i_redirect) begin
        r_pc     <= {i_redirect_pc[31:2], 2'b00};
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_pc     <= r_pc + 32'd4;
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= i_inst;
      r_mem_pc[r_wr_ptr]   <= r_pc;
    end
  end

  assign o_pc          = r_req_pc;
  assign o_fetch_valid = r_fetch_valid;
  assign o_fencei      = r_fencei;
  assign o_valid       = (r_count != '0);
  assign o_inst        = r_mem_inst[r_rd_ptr];
  assign o_inst_pc     = r_mem_pc[r_rd_ptr];

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: cache/decode stimulus with a transaction-level model and scoreboard queues.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] o_pc;
  logic        o_fetch_valid;
  logic        o_fencei;
  logic [31:0] i_inst;
  logic        i_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_valid;
  logic        i_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_fencei_req;

  ifu_fetch_ctrl #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .o_pc          (o_pc),
    .o_fetch_valid (o_fetch_valid),
    .o_fencei      (o_fencei),
    .i_inst        (i_inst),
    .i_inst_valid  (i_inst_valid),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_fencei_req  (i_fencei_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference state: next fetch address, pending fence, outstanding/flushed fetch.
  logic [31:0] m_pc;
  logic        m_fence;
  logic        m_out;
  logic        m_disc;
  logic        can_issue;
  logic [63:0] exp_dec[$];   // {inst, pc} expected at decode
  logic [32:0] exp_req[$];   // {fencei, pc} expected on the request port

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    = RESET_PC;
      m_fence = 1'b0;
      m_out   = 1'b0;
      m_disc  = 1'b0;
      exp_dec.delete();
      exp_req.delete();
    end else begin
      can_issue = !m_out && (exp_dec.size() < DEPTH) && !i_redirect;
      if (i_redirect) begin
        if (m_out && i_inst_valid) begin
          m_out  = 1'b0;
          m_disc = 1'b0;
        end else if (m_out) begin
          m_disc = 1'b1;
        end
        exp_dec.delete();
        m_pc = {i_redirect_pc[31:2], 2'b00};
      end else begin
        if (exp_dec.size() != 0 && i_ready) void'(exp_dec.pop_front());
        if (m_out && i_inst_valid) begin
          if (!m_disc) begin
            exp_dec.push_back({i_inst, m_pc});
            m_pc = m_pc + 32'd4;
          end
          m_out  = 1'b0;
          m_disc = 1'b0;
        end
      end
      if (can_issue) begin
        exp_req.push_back({m_fence, m_pc});
        m_fence = i_fencei_req;
        m_out   = 1'b1;
      end else begin
        m_fence = m_fence | i_fencei_req;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] last_req_pc;
  logic [32:0] e_req;
  logic [63:0] e_dec;
  int          resp_cnt;
  int          lat;
  logic        req_seen;
  logic        want_wait, want_resp, want_idle, want_fence, want_fredir, want_rst;

  task automatic monitor();
    req_seen = 1'b0;
    chk("fencei_without_req", 32'(o_fencei & ~o_fetch_valid), 32'd0);
    if (o_fetch_valid) begin
      req_seen = 1'b1;
      if (exp_req.size() == 0) begin
        chk("unexpected_req_pc", o_pc, 32'hxxxx_xxxx);
      end else begin
        e_req = exp_req.pop_front();
        chk("req_pc", o_pc, e_req[31:0]);
        chk("req_fencei", 32'(o_fencei), 32'(e_req[32]));
      end
      last_req_pc = o_pc;
      resp_cnt    = lat;
    end else if (exp_req.size() != 0) begin
      e_req = exp_req.pop_front();
      chk("missing_req", 32'(o_fetch_valid), 32'd1);
    end
    if (m_out) chk("req_pc_stable", o_pc, last_req_pc);
    chk("o_valid", 32'(o_valid), 32'(exp_dec.size() != 0));
    if (o_valid && exp_dec.size() != 0) begin
      e_dec = exp_dec[0];
      chk("o_inst", o_inst, e_dec[63:32]);
      chk("o_inst_pc", o_inst_pc, e_dec[31:0]);
    end
  endtask

  task automatic drive_idle();
    i_inst_valid  = 1'b0;
    i_redirect    = 1'b0;
    i_fencei_req  = 1'b0;
    i_redirect_pc = 32'h0;
    i_inst        = 32'h0;
  endtask

  initial begin
    drive_idle();
    i_ready     = 1'b1;
    rst_n       = 1'b0;
    resp_cnt    = -1;
    lat         = 2;
    last_req_pc = RESET_PC;
    {want_wait, want_resp, want_idle, want_fence, want_fredir, want_rst} = '0;
    repeat (2) @(negedge clk);
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_fetch_valid", 32'(o_fetch_valid), 32'd0);
    chk("reset_fencei", 32'(o_fencei), 32'd0);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      monitor();
      drive_idle();

      if (cyc < 200) lat = (cyc >= 95) ? 4 : 2;
      else           lat = $urandom_range(1, 4);
      if (cyc == 50)  want_wait  = 1'b1;
      if (cyc == 70)  want_resp  = 1'b1;
      if (cyc == 85)  want_idle  = 1'b1;
      if (cyc == 100) want_fence = 1'b1;
      if (cyc == 125) want_rst   = 1'b1;

      if (cyc < 20)       i_ready = 1'b1;
      else if (cyc < 45)  i_ready = (cyc == 35);
      else if (cyc < 200) i_ready = !want_rst;
      else                i_ready = ($urandom_range(0, 3) != 0);

      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          i_inst_valid = 1'b1;
          i_inst       = (cyc < 200) ? 32'h0000_0413 : $urandom;
          resp_cnt     = -1;
        end
      end else if (cyc >= 200 && !m_out && $urandom_range(0, 15) == 0) begin
        i_inst_valid = 1'b1;
        i_inst       = $urandom;
      end

      if (want_wait && m_out && !m_disc && !i_inst_valid) begin
        i_redirect = 1'b1; i_redirect_pc = 32'h3000_0103; want_wait = 1'b0;
      end else if (want_resp && i_inst_valid && m_out && !m_disc) begin
        i_redirect = 1'b1; i_redirect_pc = 32'h3000_0203; want_resp = 1'b0;
      end else if (want_idle && !m_out && exp_dec.size() < DEPTH) begin
        i_redirect = 1'b1; i_redirect_pc = 32'h3000_0301; want_idle = 1'b0;
      end else if (want_fence && req_seen) begin
        i_fencei_req = 1'b1; want_fence = 1'b0; want_fredir = 1'b1;
      end else if (want_fredir && m_out && !i_inst_valid) begin
        i_redirect = 1'b1; i_redirect_pc = 32'h3000_0010; want_fredir = 1'b0;
      end else if (cyc >= 200) begin
        if ($urandom_range(0, 19) == 0) begin
          i_redirect    = 1'b1;
          i_redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF9 : $urandom;
        end
        i_fencei_req = ($urandom_range(0, 15) == 0);
      end

      if (want_rst && ((exp_dec.size() == 1 && m_out && !m_disc && resp_cnt > 1 && !i_inst_valid)
                       || cyc == 190)) begin
        want_rst = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_o_valid", 32'(o_valid), 32'd0);
        chk("async_reset_fetch_valid", 32'(o_fetch_valid), 32'd0);
        resp_cnt = -1;
        drive_idle();
        repeat (2) @(negedge clk);
        i_ready = 1'b1;
        rst_n   = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
